// File: rtl/xnor_equiv_sequencer.sv
// Exhaustive equivalence sweep driving two N-input gate implementations in minterm order.
// Optional macro XNOR_EQUIV_STOP_ON_FAIL_EN: end the sweep at the first mismatching vector.
module xnor_equiv_sequencer #(
    parameter int N      = 2,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         res_a,
    input  logic         res_b,
    output logic [N-1:0] drive_x,
    output logic         busy,
    output logic         sample,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_count,
    output logic [N-1:0] first_fail,
    output logic         first_fail_valid
);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

    localparam logic [N-1:0] LAST_X      = {N{1'b1}};
    localparam logic [3:0]   SETTLE_LAST = 4'(SETTLE - 1);

    state_t         r_state;
    logic [N-1:0]   r_drive_x;
    logic [N:0]     r_err_count;
    logic [N-1:0]   r_first_fail;
    logic           r_first_fail_valid;
    logic           r_pass;
    logic           r_busy;
    logic           r_sample;
    logic           r_done;
    logic [3:0]     r_cnt;

    state_t         w_state_next;
    logic [N-1:0]   w_drive_next;
    logic [N:0]     w_err_next;
    logic [N-1:0]   w_ff_next;
    logic           w_ffv_next;
    logic           w_pass_next;
    logic [3:0]     w_cnt_next;
    logic           w_mismatch;

    assign w_mismatch = res_a ^ res_b;

    always_comb begin
        w_state_next = r_state;
        w_drive_next = r_drive_x;
        w_err_next   = r_err_count;
        w_ff_next    = r_first_fail;
        w_ffv_next   = r_first_fail_valid;
        w_pass_next  = r_pass;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_SETTLE;
                    w_drive_next = '0;
                    w_err_next   = '0;
                    w_ff_next    = '0;
                    w_ffv_next   = 1'b0;
                    w_pass_next  = 1'b0;
                    w_cnt_next   = '0;
                end
            end
            S_SETTLE: begin
                w_cnt_next = r_cnt + 4'd1;
                if (r_cnt == SETTLE_LAST) begin
                    w_state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_mismatch) begin
                    w_err_next = r_err_count + (N+1)'(1);
                    if (!r_first_fail_valid) begin
                        w_ff_next  = r_drive_x;
                        w_ffv_next = 1'b1;
                    end
                end
`ifdef XNOR_EQUIV_STOP_ON_FAIL_EN
                if (w_mismatch || (r_drive_x == LAST_X)) begin
`else
                if (r_drive_x == LAST_X) begin
`endif
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_SETTLE;
                    w_drive_next = r_drive_x + N'(1);
                    w_cnt_next   = '0;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        // Verdict is registered on entry to DONE so it is visible alongside the done pulse.
        if (w_state_next == S_DONE) begin
            w_pass_next = (w_err_next == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state            <= S_IDLE;
            r_drive_x          <= '0;
            r_err_count        <= '0;
            r_first_fail       <= '0;
            r_first_fail_valid <= 1'b0;
            r_pass             <= 1'b0;
            r_busy             <= 1'b0;
            r_sample           <= 1'b0;
            r_done             <= 1'b0;
            r_cnt              <= '0;
        end else begin
            r_state            <= w_state_next;
            r_drive_x          <= w_drive_next;
            r_err_count        <= w_err_next;
            r_first_fail       <= w_ff_next;
            r_first_fail_valid <= w_ffv_next;
            r_pass             <= w_pass_next;
            r_busy             <= (w_state_next == S_SETTLE) || (w_state_next == S_CHECK);
            r_sample           <= (w_state_next == S_CHECK);
            r_done             <= (w_state_next == S_DONE);
            r_cnt              <= w_cnt_next;
        end
    end

    assign drive_x          = r_drive_x;
    assign busy             = r_busy;
    assign sample           = r_sample;
    assign done             = r_done;
    assign pass             = r_pass;
    assign err_count        = r_err_count;
    assign first_fail       = r_first_fail;
    assign first_fail_valid = r_first_fail_valid;

endmodule

// File: tb/tb_xnor_equiv_sequencer.sv
// Bench for xnor_equiv_sequencer: per-sweep reference outcome derived from the injected fault mask.
module tb_xnor_equiv_sequencer;

    localparam int N = 2;
`ifdef XNOR_EQUIV_STOP_ON_FAIL_EN
    localparam int S = 2;
    localparam bit STOP = 1'b1;
`else
    localparam int S = 1;
    localparam bit STOP = 1'b0;
`endif
    localparam int NV = 2 ** N;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          res_a;
    logic          res_b;
    logic [N-1:0]  drive_x;
    logic          busy;
    logic          sample;
    logic          done;
    logic          pass;
    logic [N:0]    err_count;
    logic [N-1:0]  first_fail;
    logic          first_fail_valid;

    logic [NV-1:0] fault_mask = '0;
    int            n_tests = 0;
    int            n_fail  = 0;

    xnor_equiv_sequencer #(.N(N), .SETTLE(S)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .res_a            (res_a),
        .res_b            (res_b),
        .drive_x          (drive_x),
        .busy             (busy),
        .sample           (sample),
        .done             (done),
        .pass             (pass),
        .err_count        (err_count),
        .first_fail       (first_fail),
        .first_fail_valid (first_fail_valid)
    );

    always #5 clk = ~clk;

    // Both units model an XNOR reduction; res_b is corrupted on masked vectors.
    assign res_a = ~^drive_x;
    assign res_b = (~^drive_x) ^ fault_mask[drive_x];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sweep(input logic [NV-1:0] mask, input bit hold, input bit jitter);
        int first;
        int errs;
        int nvec;
        int exp_busy;
        int i;
        first = -1;
        errs  = 0;
        for (int v = 0; v < NV; v++) begin
            if (mask[v]) begin
                errs++;
                if (first < 0) first = v;
            end
        end
        if (STOP && first >= 0) begin
            nvec = first + 1;
            errs = 1;
        end else begin
            nvec = NV;
        end
        exp_busy = nvec * (S + 1);

        fault_mask = mask;
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        i = 0;
        while (busy === 1'b1 && i < 1000) begin
            chk("drive_x", 32'(drive_x), 32'(i / (S + 1)));
            chk("sample", 32'(sample), 32'((i % (S + 1)) == S));
            chk("done_busy", 32'(done), 32'(0));
            i++;
            if (jitter) start = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        if (!hold) start = 1'b0;
        $display("[TB] sweep mask=%b busy_cycles=%0d err=%0d pass=%0b ff=%0d ffv=%0b",
                 mask, i, err_count, pass, first_fail, first_fail_valid);
        chk("busy_cycles", 32'(i), 32'(exp_busy));
        chk("done", 32'(done), 32'(1));
        chk("pass", 32'(pass), 32'(errs == 0));
        chk("err_count", 32'(err_count), 32'(errs));
        chk("ff_valid", 32'(first_fail_valid), 32'(first >= 0));
        chk("first_fail", 32'(first_fail), 32'((first >= 0) ? first : 0));
        chk("drive_x_done", 32'(drive_x), 32'(nvec - 1));
        @(negedge clk);
        chk("done_after", 32'(done), 32'(0));
        chk("busy_after", 32'(busy), 32'(0));
        chk("pass_held", 32'(pass), 32'(errs == 0));
    endtask

    initial begin
        bit found;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_sample", 32'(sample), 32'(0));
        chk("rst_pass", 32'(pass), 32'(0));
        chk("rst_drive_x", 32'(drive_x), 32'(0));
        chk("rst_err", 32'(err_count), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'(0));

        sweep(4'b0000, 1'b0, 1'b0);
        sweep(4'b0100, 1'b0, 1'b0);
        sweep(4'b1111, 1'b0, 1'b0);
        sweep(4'b0010, 1'b0, 1'b0);

        // Abort a sweep with reset while vector 2 is applied.
        fault_mask = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (drive_x === N'(2)) found = 1'b1;
            else @(negedge clk);
        end
        chk("reach_x2", 32'(found), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_drive_x", 32'(drive_x), 32'(0));
        chk("abort_sample", 32'(sample), 32'(0));
        chk("abort_err", 32'(err_count), 32'(0));
        @(negedge clk);
        chk("abort_done", 32'(done), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_no_done", 32'(done), 32'(0));
        sweep(4'b0000, 1'b0, 1'b0);

        // start held high: back-to-back sweeps with one idle cycle between.
        sweep(4'b0000, 1'b1, 1'b0);
        sweep(4'b1000, 1'b1, 1'b0);
        start = 1'b0;
        @(negedge clk);

        // Random fault masks with start toggling while busy.
        for (int r = 0; r < 8; r++) begin
            sweep(NV'($urandom), 1'b0, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
